// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: state encoding, default
// memory depth, word geometry and the COUNT legality rule.
package loader_pkg;

   localparam int unsigned DEPTH_DEFAULT  = 18;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTE_W         = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_WRITE = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // A load request is legal only for 1..depth words.
   function automatic logic count_legal(input logic [31:0] count,
                                        input logic [31:0] depth);
      return (count != 32'd0) && (count <= depth);
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects stream bytes MSB-first into a 32-bit word; word_full_c pulses with
// the byte that completes the word, when word_c already holds the full value.
module word_assembler
   import loader_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr_i,
   input  logic                shift_i,
   input  logic [BYTE_W-1:0]   byte_i,
   output logic [WORD_W-1:0]   word_c,
   output logic                word_full_c
);

   localparam int unsigned HIST_W = WORD_W - BYTE_W;

   logic [HIST_W-1:0]     hist_q;
   logic [BYTE_CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
         hist_q <= '0;
         cnt_q  <= '0;
      end else if (shift_i) begin
         hist_q <= {hist_q[HIST_W-BYTE_W-1:0], byte_i};
         cnt_q  <= cnt_q + 1'b1;
      end
   end

   assign word_c      = {hist_q, byte_i};
   assign word_full_c = shift_i && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Streams bytes into 32-bit instruction-memory writes at addresses 0..COUNT-1.
// Build with LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instruction_loader
   import loader_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT,
   parameter int unsigned CNT_W = 5
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                START,
   input  logic [CNT_W-1:0]    COUNT,
   input  logic [BYTE_W-1:0]   IN_DATA,
   input  logic                IN_VALID,
   output logic                IN_READY,
   output logic                WE,
   output logic signed [31:0]  WA,
   output logic [WORD_W-1:0]   WD,
   output logic                BUSY,
   output logic                DONE,
   output logic                ERR
);

   state_e             state_q;
   logic [CNT_W-1:0]   idx_q;
   logic [CNT_W-1:0]   last_q;
   logic               in_ready_q;
   logic               we_q;
   logic signed [31:0] wa_q;
   logic [WORD_W-1:0]  wd_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;
`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0]  xor_q;
`endif

   logic              xfer_c;
   logic              load_xfer_c;
   logic              start_req_c;
   logic              start_ok_c;
   logic [WORD_W-1:0] word_c;
   logic              word_full_c;

   assign xfer_c      = IN_VALID && in_ready_q;
   assign load_xfer_c = xfer_c && (state_q == ST_LOAD);
   assign start_req_c = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign start_ok_c  = count_legal(32'(COUNT), 32'(DEPTH));

   // Clearing on an accepted START drops any stale partial word.
   word_assembler u_asm (
      .clk         (CLK),
      .rst_n       (RST_N),
      .clr_i       (start_req_c && start_ok_c),
      .shift_i     (load_xfer_c),
      .byte_i      (IN_DATA),
      .word_c      (word_c),
      .word_full_c (word_full_c)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         last_q     <= '0;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         wa_q       <= '0;
         wd_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         we_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_req_c) begin
                  if (start_ok_c) begin
                     state_q    <= ST_LOAD;
                     idx_q      <= '0;
                     last_q     <= CNT_W'(COUNT - 1'b1);
                     in_ready_q <= 1'b1;
                     busy_q     <= 1'b1;
                     done_q     <= 1'b0;
                     err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                     xor_q      <= '0;
`endif
                  end else begin
                     state_q <= ST_IDLE;
                     err_q   <= 1'b1;
                     done_q  <= 1'b0;
                  end
               end
            end

            ST_LOAD: begin
               if (load_xfer_c) begin
`ifdef LOADER_CHECKSUM_EN
                  xor_q <= xor_q ^ IN_DATA;
`endif
                  if (word_full_c) begin
                     state_q    <= ST_WRITE;
                     in_ready_q <= 1'b0;
                     we_q       <= 1'b1;
                     wa_q       <= 32'(idx_q);
                     wd_q       <= word_c;
                  end
               end
            end

            // The write strobe is already on the outputs; advance the index.
            ST_WRITE: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == last_q) begin
`ifdef LOADER_CHECKSUM_EN
                  state_q    <= ST_CHECK;
                  in_ready_q <= 1'b1;
`else
                  state_q    <= ST_DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
`endif
               end else begin
                  state_q    <= ST_LOAD;
                  in_ready_q <= 1'b1;
               end
            end

`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (xfer_c) begin
                  err_q      <= (IN_DATA != xor_q);
                  state_q    <= ST_DONE;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
               end
            end
`endif

            default: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign IN_READY = in_ready_q;
   assign WE       = we_q;
   assign WA       = wa_q;
   assign WD       = wd_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes are queued at
// stimulus time and a negedge monitor checks every WE against them.
module tb_instruction_loader;

   localparam int DEPTH = 18;
   localparam int CNT_W = 5;

   logic               CLK;
   logic               RST_N;
   logic               START;
   logic [CNT_W-1:0]   COUNT;
   logic [7:0]         IN_DATA;
   logic               IN_VALID;
   logic               IN_READY;
   logic               WE;
   logic signed [31:0] WA;
   logic [31:0]        WD;
   logic               BUSY;
   logic               DONE;
   logic               ERR;

   instruction_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .START    (START),
      .COUNT    (COUNT),
      .IN_DATA  (IN_DATA),
      .IN_VALID (IN_VALID),
      .IN_READY (IN_READY),
      .WE       (WE),
      .WA       (WA),
      .WD       (WD),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .ERR      (ERR)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   wr_t        mon_e;
   logic [7:0] stim[$];
   int         vectors     = 0;
   int         miscompares = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
      end
   endtask

   // Monitor: every write strobe must match the oldest queued expectation.
   always @(negedge CLK) begin
      if (WE) begin
         if (!RST_N || exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_we: got WA=%0d WD=0x%08h, expected no write", WA, WD);
         end else begin
            mon_e = exp_q.pop_front();
            chk("we_addr", WA, mon_e.addr);
            chk("we_data", WD, mon_e.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_rdy);
      bit ok;
      ok       = 1'b0;
      IN_VALID = 1'b1;
      IN_DATA  = b;
      for (int k = 0; k < 64 && !ok; k++) begin
         @(negedge CLK);
         ok = IN_READY;
         @(posedge CLK);
         #1;
      end
      IN_VALID = 1'b0;
      IN_DATA  = 8'($urandom);
      chk("byte_accepted", 32'(ok), 32'd1);
      for (int g = 0; g < gap; g++) begin
         @(negedge CLK);
         if (chk_rdy) chk("in_ready_hold", 32'(IN_READY), 32'd1);
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic pulse_start(input int cnt);
      START = 1'b1;
      COUNT = CNT_W'(cnt);
      @(posedge CLK);
      #1;
      START = 1'b0;
      COUNT = CNT_W'($urandom);
   endtask

   // One complete load of cnt words from stim; illegal cnt expects only ERR.
   task automatic do_load(input int cnt, input int glo, input int ghi, input bit chk_rdy,
                          input int pulse_at, input bit bad_ck);
      logic [7:0] ck;
      bit         exp_err;
      bit         legal;
      int         k;
      legal   = (cnt >= 1) && (cnt <= DEPTH);
      exp_err = 1'b0;
      ck      = 8'h00;
      if (legal) begin
         for (int w = 0; w < cnt; w++) begin
            wr_t e;
            e.addr = 32'(w);
            e.data = 32'd0;
            for (int b = 0; b < 4; b++) e.data = e.data * 256 + 32'(stim[4*w+b]);
            exp_q.push_back(e);
         end
      end
      pulse_start(cnt);
      if (!legal) begin
         repeat (3) @(negedge CLK);
         chk("illegal_err", 32'(ERR), 32'd1);
         chk("illegal_done", 32'(DONE), 32'd0);
         chk("illegal_busy", 32'(BUSY), 32'd0);
         chk("illegal_ready", 32'(IN_READY), 32'd0);
         @(posedge CLK);
         #1;
         return;
      end
      @(negedge CLK);
      chk("busy_after_start", 32'(BUSY), 32'd1);
      chk("done_cleared", 32'(DONE), 32'd0);
      chk("err_cleared", 32'(ERR), 32'd0);
      @(posedge CLK);
      #1;
      for (int i = 0; i < cnt * 4; i++) begin
         ck = ck ^ stim[i];
         send_byte(stim[i], $urandom_range(ghi, glo), chk_rdy && ((i % 4) != 3));
         if (i == pulse_at) pulse_start($urandom_range(DEPTH, 1));
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_ck ? (ck ^ 8'h01) : ck, 0, 1'b0);
      exp_err = bad_ck;
`endif
      k = 0;
      while (k < 64 && !DONE) begin
         @(negedge CLK);
         k++;
      end
      chk("done_set", 32'(DONE), 32'd1);
      chk("busy_clear", 32'(BUSY), 32'd0);
      chk("err_final", 32'(ERR), 32'(exp_err));
      chk("writes_pending", 32'(exp_q.size()), 32'd0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      int cnt;
      RST_N    = 1'b0;
      START    = 1'b0;
      COUNT    = '0;
      IN_DATA  = '0;
      IN_VALID = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("rst_in_ready", 32'(IN_READY), 32'd0);
      chk("rst_we", 32'(WE), 32'd0);
      chk("rst_wa", WA, 32'd0);
      chk("rst_wd", WD, 32'd0);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      stim = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      do_load(2, 0, 0, 1'b0, -1, 1'b0);
      do_load(2, 3, 3, 1'b1, -1, 1'b0);

      do_load(0, 0, 0, 1'b0, -1, 1'b0);
      do_load(19, 0, 0, 1'b0, -1, 1'b0);

      // Reset after two bytes of word 1; the partial bytes must vanish.
      stim = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      exp_q.push_back({32'd0, 32'h11223344});
      pulse_start(2);
      for (int i = 0; i < 6; i++) send_byte(stim[i], 0, 1'b0);
      chk("pre_reset_writes", 32'(exp_q.size()), 32'd0);
      RST_N = 1'b0;
      @(negedge CLK);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("midrst_busy", 32'(BUSY), 32'd0);
      chk("midrst_ready", 32'(IN_READY), 32'd0);
      chk("midrst_we", 32'(WE), 32'd0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      stim = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_load(1, 0, 0, 1'b0, -1, 1'b0);

      stim = {};
      for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
      do_load(4, 0, 1, 1'b0, 5, 1'b0);

      stim = {8'h01, 8'h02, 8'h04, 8'h08};
      do_load(1, 0, 0, 1'b0, -1, 1'b0);
      do_load(1, 0, 0, 1'b0, -1, 1'b1);

      for (int n = 0; n < 10; n++) begin
         if ($urandom_range(3, 0) == 0) cnt = (n % 2 == 0) ? 0 : $urandom_range(31, DEPTH + 1);
         else cnt = $urandom_range(DEPTH, 1);
         stim = {};
         for (int i = 0; i < cnt * 4; i++) stim.push_back(8'($urandom));
         do_load(cnt, 0, 2, 1'b0, (n == 3) ? 2 : -1, 1'($urandom_range(1, 0)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writer-side companion to the instruction memory. It accepts a byte stream over a valid/ready handshake, assembles the bytes into 32-bit instruction words and writes them to sequential instruction-memory addresses starting at 0. While a load is in progress it holds the processor via BUSY, so a program can be replaced without re-elaborating the memory image.

## Interface
Parameters:
- DEPTH, 18: number of instruction words in the target memory; legal COUNT is 1..DEPTH.
- CNT_W, 5: width of COUNT and of the internal word index; must satisfy 2^CNT_W > DEPTH.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  single-cycle request to begin a load; sampled only in IDLE or DONE.
- COUNT  in  CNT_W  number of words to load; sampled in the same cycle as START.
- IN_DATA  in  8  stream byte.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  loader accepts a byte; a transfer occurs when IN_VALID and IN_READY are both 1.
- WE  out  1  instruction-memory write strobe, one cycle per word.
- WA  out  32  write word address; signed 32, matching the memory read address.
- WD  out  32  write data.
- BUSY  out  1  load in progress; the processor is stalled while this is 1.
- DONE  out  1  last load finished; held until the next accepted START.
- ERR  out  1  error flag from the last START or load; held until the next accepted START.

## Operation
- States:
  - IDLE: reset state.
  - LOAD: collects bytes.
  - WRITE: issues one memory write.
  - CHECK: present only with the checksum feature.
  - DONE: load complete.
- IDLE/DONE + START:
  - If 1 ≤ COUNT ≤ DEPTH: go to LOAD and clear word index, byte count, DONE and ERR.
  - Otherwise: set ERR=1 and DONE=0, stay in or return to IDLE, and issue no writes.
- LOAD:
  - IN_READY=1 and BUSY=1.
  - Bytes assemble MSB-first: the 1st accepted byte goes to bits [31:24] and the 4th to bits [7:0].
  - On the 4th transfer, go to WRITE.
- WRITE:
  - For one cycle: IN_READY=0, WE=1, WA=word index (zero-extended), WD=assembled word.
  - Next, increment the word index.
  - If the written word was word COUNT-1, go to DONE (or CHECK when the checksum is built in). Otherwise go back to LOAD.
- DONE: BUSY=0, DONE=1, IN_READY=0.
- START asserted in LOAD, WRITE or CHECK is ignored.
- Bytes are never dropped or consumed while IN_READY=0.
- Reset values for all outputs: IN_READY, WE, BUSY, DONE, ERR = 0; WA, WD = 0; state = IDLE.
- Reset mid-load:
  - Any partial word is discarded.
  - No WE is issued in the reset cycle or the cycle after it.
  - Words already written remain in memory.
- WA never exceeds DEPTH-1, and the word index never wraps.

## Timing
- WE is asserted in the cycle immediately after the 4th byte of a word is accepted.
- Best-case throughput is 4 bytes per 5 cycles, because of the WRITE bubble.
- DONE rises one cycle after the final WE, or one cycle after the checksum byte when the checksum is built in.
- BUSY falls in the same cycle that DONE rises.
- BUSY is 1 from the cycle after an accepted START until DONE rises.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Keep a running 8-bit XOR of all data bytes.
  - After the last WRITE, enter CHECK with IN_READY=1 and accept exactly one checksum byte.
  - If that byte differs from the running XOR, set ERR=1.
  - Go to DONE either way; DONE=1 on both match and mismatch.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK state and no XOR register.
  - ERR is set only by an illegal COUNT.

## Structure
- Shared package loader_pkg holds:
  - the state encoding (IDLE, LOAD, WRITE, CHECK, DONE);
  - default DEPTH=18;
  - BYTES_PER_WORD=4.
- One sub-module, word_assembler, holds the 32-bit shift register and the 2-bit byte counter. Its outputs are the assembled word and a word_full pulse. The top level holds the FSM, the word index, the checksum and the outputs.

## Test plan
- Reset, then START with COUNT=2 and bytes 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xF0 sent back-to-back:
  - WE at WA=0, WD=0x12345678, then WE at WA=1, WD=0x9ABCDEF0;
  - DONE=1, BUSY=0, ERR=0.
- The same stream with IN_VALID deasserted for 3 cycles after every byte: identical writes; IN_READY holds 1 during LOAD; no extra WE.
- START with COUNT=0, and separately with COUNT=19: ERR=1, no WE, BUSY stays 0.
- Drive RST_N low after 2 bytes of word 1, then release and START with COUNT=1 and bytes 0xAA,0xBB,0xCC,0xDD: single write WA=0, WD=0xAABBCCDD; the old partial bytes never appear.
- START pulsed during LOAD: ignored; the load completes with the original COUNT.
- LOADER_CHECKSUM_EN defined, COUNT=1, bytes 0x01,0x02,0x04,0x08:
  - checksum byte 0x0F gives ERR=0 and DONE=1;
  - checksum byte 0x0E gives ERR=1 and DONE=1.
